// File: rtl/target_frame_sequencer_if.sv
// Target stream bundle: one snapshot target word per valid/ready handshake.
// master = sequencer side (drives word + valid), slave = consumer side (drives ready).
interface target_frame_sequencer_if #(
    parameter int W_H = 12,
    parameter int W_V = 11
);
    logic           tgt_valid_out;
    logic           tgt_ready_in;
    logic [1:0]     tgt_idx_out;
    logic [W_H-1:0] tgt_x_out;
    logic [W_V-1:0] tgt_y_out;
    logic [W_V-1:0] tgt_diam_out;

    modport master (
        output tgt_valid_out,
        output tgt_idx_out,
        output tgt_x_out,
        output tgt_y_out,
        output tgt_diam_out,
        input  tgt_ready_in
    );

    modport slave (
        input  tgt_valid_out,
        input  tgt_idx_out,
        input  tgt_x_out,
        input  tgt_y_out,
        input  tgt_diam_out,
        output tgt_ready_in
    );
endinterface

// File: rtl/target_frame_sequencer.sv
// Frame-level target sequencer: snapshots 4 marker results at vblank start,
// tracks lock/loss, and streams each eligible target over tgt_if.
// Ports: clk_in, rst_in (sync, active-high); hcount_in/vcount_in raster position;
//   xcount*/ycount*/diam*_in target data; valid_in[3]=target0..valid_in[0]=target3;
//   tgt_if (master) stream word; frame_done_out/tgt_count_out end-of-frame;
//   lock_out, lost_out, overrun_out status.
// Optional: define TARGET_SEQ_FILTER_EN to drop targets with diameter < MIN_DIAMETER.
module target_frame_sequencer #(
    parameter int SCREEN_WIDTH  = 1280,
    parameter int SCREEN_HEIGHT = 720,
    parameter int LOCK_FRAMES   = 3,
    parameter int LOST_FRAMES   = 8,
    parameter int MIN_DIAMETER  = 4,
    localparam int W_H = $clog2(SCREEN_WIDTH) + 1,
    localparam int W_V = $clog2(SCREEN_HEIGHT) + 1
) (
    input  logic           clk_in,
    input  logic           rst_in,
    input  logic [W_H-1:0] hcount_in,
    input  logic [W_V-1:0] vcount_in,
    input  logic [W_H-1:0] xcount0_in,
    input  logic [W_H-1:0] xcount1_in,
    input  logic [W_H-1:0] xcount2_in,
    input  logic [W_H-1:0] xcount3_in,
    input  logic [W_V-1:0] ycount0_in,
    input  logic [W_V-1:0] ycount1_in,
    input  logic [W_V-1:0] ycount2_in,
    input  logic [W_V-1:0] ycount3_in,
    input  logic [W_V-1:0] diam0_in,
    input  logic [W_V-1:0] diam1_in,
    input  logic [W_V-1:0] diam2_in,
    input  logic [W_V-1:0] diam3_in,
    input  logic [3:0]     valid_in,
    target_frame_sequencer_if.master tgt_if,
    output logic           frame_done_out,
    output logic [2:0]     tgt_count_out,
    output logic           lock_out,
    output logic           lost_out,
    output logic           overrun_out
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_SEND,
        S_DONE
    } state_t;

    localparam logic [3:0]     LOCK_N = 4'(LOCK_FRAMES);
    localparam logic [3:0]     LOST_N = 4'(LOST_FRAMES);
    localparam logic [W_V-1:0] MIN_D  = W_V'(MIN_DIAMETER);

    state_t         r_state;
    state_t         w_state_n;

    logic [W_H-1:0] r_x [4];
    logic [W_V-1:0] r_y [4];
    logic [W_V-1:0] r_d [4];
    logic [3:0]     r_elig;
    logic [1:0]     r_idx;
    logic [2:0]     r_count;
    logic [3:0]     r_good;
    logic [3:0]     r_bad;
    logic           r_lock;
    logic           r_lost;
    logic           r_overrun;
    logic           r_strb_d;

    logic [W_H-1:0] w_x_in [4];
    logic [W_V-1:0] w_y_in [4];
    logic [W_V-1:0] w_d_in [4];
    logic [3:0]     w_elig_in;
    logic           w_strb_lvl;
    logic           w_strobe;
    logic [3:0]     w_src;
    logic           w_any;
    logic [1:0]     w_pick;
    logic           w_capture;
    logic           w_load;
    logic           w_ack;
    logic           w_valid;
    logic           w_done;
    logic [3:0]     w_good_inc;
    logic [3:0]     w_bad_inc;

    function automatic logic [1:0] f_lowest(input logic [3:0] m);
        logic [1:0] r;
        r = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) r = 2'(i);
        end
        return r;
    endfunction

    assign w_x_in[0] = xcount0_in;
    assign w_x_in[1] = xcount1_in;
    assign w_x_in[2] = xcount2_in;
    assign w_x_in[3] = xcount3_in;
    assign w_y_in[0] = ycount0_in;
    assign w_y_in[1] = ycount1_in;
    assign w_y_in[2] = ycount2_in;
    assign w_y_in[3] = ycount3_in;
    assign w_d_in[0] = diam0_in;
    assign w_d_in[1] = diam1_in;
    assign w_d_in[2] = diam2_in;
    assign w_d_in[3] = diam3_in;

    // valid_in is MSB-first: bit 3 belongs to target 0.
`ifdef TARGET_SEQ_FILTER_EN
    always_comb begin
        w_elig_in = '0;
        for (int i = 0; i < 4; i++) begin
            w_elig_in[i] = valid_in[3-i] && (w_d_in[i] >= MIN_D);
        end
    end
`else
    logic [W_V-1:0] w_unused_min;
    assign w_unused_min = MIN_D;
    always_comb begin
        w_elig_in = '0;
        for (int i = 0; i < 4; i++) begin
            w_elig_in[i] = valid_in[3-i];
        end
    end
`endif

    assign w_strb_lvl = (hcount_in == '0) &&
                        (vcount_in == W_V'(SCREEN_HEIGHT));
    assign w_strobe   = w_strb_lvl && !r_strb_d;

    // In SEND the word on the bus is already being retired, so look past it.
    assign w_src  = (r_state == S_SEND) ?
                    (r_elig & ~(4'b0001 << r_idx)) : r_elig;
    assign w_any  = |w_src;
    assign w_pick = f_lowest(w_src);

    assign w_good_inc = (r_good == 4'hF) ? 4'hF : r_good + 4'd1;
    assign w_bad_inc  = (r_bad  == 4'hF) ? 4'hF : r_bad  + 4'd1;

    always_ff @(posedge clk_in) begin
        if (rst_in) r_state <= S_IDLE;
        else        r_state <= w_state_n;
    end

    always_comb begin
        w_state_n = r_state;
        w_capture = 1'b0;
        w_load    = 1'b0;
        w_ack     = 1'b0;
        w_valid   = 1'b0;
        w_done    = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (w_strobe) begin
                    w_capture = 1'b1;
                    w_state_n = S_SCAN;
                end
            end
            S_SCAN: begin
                if (w_any) begin
                    w_load    = 1'b1;
                    w_state_n = S_SEND;
                end else begin
                    w_state_n = S_DONE;
                end
            end
            S_SEND: begin
                w_valid = 1'b1;
                if (tgt_if.tgt_ready_in) begin
                    w_ack = 1'b1;
                    if (w_any) w_load    = 1'b1;
                    else       w_state_n = S_DONE;
                end
            end
            S_DONE: begin
                w_done    = 1'b1;
                w_state_n = S_IDLE;
            end
            default: w_state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int i = 0; i < 4; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
                r_d[i] <= '0;
            end
            r_elig    <= '0;
            r_idx     <= '0;
            r_count   <= '0;
            r_good    <= '0;
            r_bad     <= '0;
            r_lock    <= 1'b0;
            r_lost    <= 1'b0;
            r_overrun <= 1'b0;
            r_strb_d  <= 1'b0;
        end else begin
            r_strb_d  <= w_strb_lvl;
            r_overrun <= w_strobe && (r_state != S_IDLE);
            r_lost    <= 1'b0;
            if (w_capture) begin
                for (int i = 0; i < 4; i++) begin
                    r_x[i] <= w_x_in[i];
                    r_y[i] <= w_y_in[i];
                    r_d[i] <= w_d_in[i];
                end
                r_elig  <= w_elig_in;
                r_count <= '0;
                if (&w_elig_in) begin
                    r_good <= w_good_inc;
                    r_bad  <= '0;
                    if (w_good_inc >= LOCK_N) r_lock <= 1'b1;
                end else begin
                    r_good <= '0;
                    r_bad  <= w_bad_inc;
                    if (r_lock && (w_bad_inc >= LOST_N)) begin
                        r_lock <= 1'b0;
                        r_lost <= 1'b1;
                    end
                end
            end
            if (w_ack) begin
                r_elig[r_idx] <= 1'b0;
                r_count       <= r_count + 3'd1;
            end
            if (w_load) r_idx <= w_pick;
        end
    end

    assign tgt_if.tgt_valid_out = w_valid;
    assign tgt_if.tgt_idx_out   = r_idx;
    assign tgt_if.tgt_x_out     = r_x[r_idx];
    assign tgt_if.tgt_y_out     = r_y[r_idx];
    assign tgt_if.tgt_diam_out  = r_d[r_idx];

    assign frame_done_out = w_done;
    assign tgt_count_out  = w_done ? r_count : 3'd0;
    assign lock_out       = r_lock;
    assign lost_out       = r_lost;
    assign overrun_out    = r_overrun;

endmodule
